booth2_product_accumulator: RTL and testbench
=============================================

Name: booth2_product_accumulator

Overview:
Downstream consumer of the 8x8 signed radix-4 Booth multiplier's 16-bit final_result. It accumulates a vector of signed products into a wide signed sum, forming the dot-product stage.
- Uses a valid/ready handshake on both sides.
- Terminates a vector on a fixed length or an early last flag.
- Saturates on overflow and flags it.

Parameters:
PROD_W, 16, signed product width (multiplier output width).
ACC_W, 20, signed accumulator/result width; must be >= PROD_W.
VEC_LEN, 8, maximum products per vector (>= 1); vector closes automatically on beat VEC_LEN.
CNT_W, $clog2(VEC_LEN+1), width of beat counter / result_cnt.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
clear  input  1  synchronous abort of current vector.
prod_valid  input  1  product beat valid.
prod_ready  output  1  block can accept a product beat.
product  input  PROD_W  signed product (multiplier final_result).
prod_last  input  1  beat is last of vector (qualified by prod_valid).
out_valid  output  1  result available.
out_ready  input  1  downstream accepts result.
result  output  ACC_W  signed saturated vector sum.
result_cnt  output  CNT_W  number of beats in the vector.
result_ovf  output  1  saturation occurred at least once in the vector.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). Reset dominates clear; clear dominates all other inputs.
- Reset/clear values: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, result=0, result_cnt=0, result_ovf=0, prod_ready=1 (registered).
- States:
  - IDLE: acc=0, no beats taken.
  - ACCUM: at least one beat taken.
  - DONE: holding result.
- prod_ready=1 in IDLE/ACCUM, 0 in DONE. Beat accepted iff prod_valid && prod_ready.
- On an accepted beat:
  - Compute sum = acc + sign_extend(product) at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc takes max positive and ovf<=1.
  - If sum < -2^(ACC_W-1), acc takes min negative and ovf<=1.
  - Otherwise acc<=sum[ACC_W-1:0].
  - count<=count+1.
- Vector close: the accepted beat has prod_last=1, or count+1==VEC_LEN. In that case, in the same edge:
  - result<=new acc, result_cnt<=count+1, result_ovf<=new ovf.
  - out_valid<=1, state<=DONE.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Non-closing accepted beat: IDLE->ACCUM, or stay ACCUM.
- DONE:
  - result/result_cnt/result_ovf stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0, acc<=0, count<=0, ovf<=0, state<=IDLE, prod_ready<=1.
  - First new beat is accepted the cycle after the handoff; there is no same-cycle overlap.
- prod_last ignored when prod_valid=0 or prod_ready=0. prod_valid with no prod_last in IDLE simply starts a vector.
- VEC_LEN=1: every accepted beat closes immediately.
- clear mid-vector or in DONE: the partial sum and any pending result are discarded; no out_valid is produced for that vector.
- Saturation is sticky: later beats continue from the saturated acc value and may come back into range; result_ovf stays 1.

Decomposition:
- Shared package booth2_pkg holds:
  - PROD_W=16 and the multiplier operand width 8.
  - State enum typedef acc_state_t {IDLE, ACCUM, DONE}.
  - Function sat_add(acc, prod) returning {ovf, value}.
- One natural sub-module: booth2_sat_adder (combinational, ACC_W-parameterised sign-extend + saturating add). The FSM, counter and output registers stay in the top.

Test Plan:
- Six-beat vector, prod_last on beat 6. Products 0xEE56(-4522), 0x0736(1846), 0x0CD6(3286), 0x1E06(7686), 0xFFF6(-10), 0x0F81(3969) -> out_valid one cycle after beat 6; result=12255 (0x02FDF), result_cnt=6, result_ovf=0.
- Eight beats of 16384 (0x4000), no prod_last, VEC_LEN=8, ACC_W=18 instance -> result saturates to 131071, result_ovf=1, cnt=8. Same stream with ACC_W=20 -> result 131072, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0 throughout, result stable. out_ready=1 -> next cycle IDLE, the following beat is accepted and starts from acc=0.
- clear asserted after 3 beats of 1000 -> no out_valid. Next vector of single beat -7 with prod_last -> result=-7 (0xFFFF9), cnt=1.
- RST asserted in DONE with out_valid=1 -> next edge: all outputs zero, prod_ready=1. RST and clear together behave identically to RST.
- Eight beats of 0x8000 (-32768), ACC_W=18 -> saturates at -131072, result_ovf=1.

Source files
------------

// File: rtl/booth2_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier and its dot-product stage.
// sat_add works at a fixed wide width so one function serves any accumulator width.
package booth2_pkg;

  localparam int PROD_W    = 16;
  localparam int MULT_W    = 8;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

  // Inputs arrive already sign-extended; acc_w (< SAT_MAX_W) sets the clamp range.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] acc,
    input logic signed [SAT_MAX_W-1:0] prod,
    input int                          acc_w
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] sum;
    logic signed [SAT_MAX_W-1:0] max_pos;
    logic signed [SAT_MAX_W-1:0] min_neg;
    logic                        ovf;
    logic signed [SAT_MAX_W-1:0] value;
    one     = 1;
    sum     = acc + prod;
    max_pos = (one <<< (acc_w - 1)) - one;
    min_neg = -max_pos - one;
    if (sum > max_pos) begin
      ovf   = 1'b1;
      value = max_pos;
    end else if (sum < min_neg) begin
      ovf   = 1'b1;
      value = min_neg;
    end else begin
      ovf   = 1'b0;
      value = sum;
    end
    return {ovf, value};
  endfunction

endpackage

// File: rtl/booth2_sat_adder.sv
// Combinational sign-extend and saturating add of one product into the accumulator.
module booth2_sat_adder
  import booth2_pkg::*;
#(
  parameter int PROD_W = booth2_pkg::PROD_W,
  parameter int ACC_W  = 20
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] product,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  logic signed [SAT_MAX_W-1:0] acc_wide;
  logic signed [SAT_MAX_W-1:0] prod_wide;
  logic        [SAT_MAX_W-1:0] sat_value;
  logic                        unused_hi;

  assign acc_wide  = SAT_MAX_W'(acc);
  assign prod_wide = SAT_MAX_W'(product);

  assign {ovf, sat_value} = sat_add(acc_wide, prod_wide, ACC_W);

  // The upper bits only repeat the sign of the clamped value.
  assign sum       = sat_value[ACC_W-1:0];
  assign unused_hi = ^sat_value[SAT_MAX_W-1:ACC_W];

endmodule

// File: rtl/booth2_product_accumulator.sv
// Dot-product stage: sums a vector of signed Booth products with saturation,
// closing on prod_last or after VEC_LEN beats, and holds the result until taken.
module booth2_product_accumulator
  import booth2_pkg::*;
#(
  parameter int PROD_W  = booth2_pkg::PROD_W,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] product,
  input  logic                     prod_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  result,
  output logic        [CNT_W-1:0]  result_cnt,
  output logic                     result_ovf
);

  acc_state_t              state;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] count;
  logic                    ovf;

  logic signed [ACC_W-1:0] sum_val;
  logic                    sum_ovf;
  logic                    ovf_next;
  logic        [CNT_W-1:0] cnt_next;
  logic                    beat_ok;
  logic                    closing;

  booth2_sat_adder #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .acc    (acc),
    .product(product),
    .sum    (sum_val),
    .ovf    (sum_ovf)
  );

  assign beat_ok  = prod_valid && prod_ready;
  assign cnt_next = count + CNT_W'(1);
  assign ovf_next = ovf || sum_ovf;
  assign closing  = prod_last || (cnt_next == CNT_W'(VEC_LEN));

  // prod_ready is only high in IDLE/ACCUM, so beat_ok never fires in DONE.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      result_cnt <= '0;
      result_ovf <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat_ok) begin
            acc   <= sum_val;
            count <= cnt_next;
            ovf   <= ovf_next;
            if (closing) begin
              result     <= sum_val;
              result_cnt <= cnt_next;
              result_ovf <= ovf_next;
              out_valid  <= 1'b1;
              prod_ready <= 1'b0;
              state      <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth2_product_accumulator.sv
// Directed vector bench: an ACC_W=20 instance (a_*) and an ACC_W=18 instance (b_*)
// sharing clock and reset, checked against hand-computed sums.
module tb_booth2_product_accumulator;

  logic CLK = 1'b0;
  logic RST;

  logic               a_clear, a_prod_valid, a_prod_ready, a_prod_last;
  logic signed [15:0] a_product;
  logic               a_out_valid, a_out_ready, a_result_ovf;
  logic signed [19:0] a_result;
  logic        [3:0]  a_result_cnt;

  logic               b_clear, b_prod_valid, b_prod_ready, b_prod_last;
  logic signed [15:0] b_product;
  logic               b_out_valid, b_out_ready, b_result_ovf;
  logic signed [17:0] b_result;
  logic        [3:0]  b_result_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string              name;
    int                 inst;
    int                 n;
    int                 use_last;
    logic signed [15:0] p [8];
    int                 exp_res;
    int                 exp_cnt;
    int                 exp_ovf;
  } vec_t;

  vec_t vecs [6];

  always #5 CLK = ~CLK;

  booth2_product_accumulator #(.ACC_W(20), .VEC_LEN(8)) dut_a (
    .CLK(CLK), .RST(RST), .clear(a_clear),
    .prod_valid(a_prod_valid), .prod_ready(a_prod_ready),
    .product(a_product), .prod_last(a_prod_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .result_cnt(a_result_cnt), .result_ovf(a_result_ovf)
  );

  booth2_product_accumulator #(.ACC_W(18), .VEC_LEN(8)) dut_b (
    .CLK(CLK), .RST(RST), .clear(b_clear),
    .prod_valid(b_prod_valid), .prod_ready(b_prod_ready),
    .product(b_product), .prod_last(b_prod_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .result_cnt(b_result_cnt), .result_ovf(b_result_ovf)
  );

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic read_out(input int inst, output int ov, output int res,
                          output int cnt, output int ovf, output int pr);
    if (inst == 0) begin
      ov = a_out_valid; res = a_result; cnt = a_result_cnt;
      ovf = a_result_ovf; pr = a_prod_ready;
    end else begin
      ov = b_out_valid; res = b_result; cnt = b_result_cnt;
      ovf = b_result_ovf; pr = b_prod_ready;
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic v,
                                input logic signed [15:0] p, input logic l);
    if (inst == 0) begin
      a_prod_valid = v; a_product = p; a_prod_last = l;
    end else begin
      b_prod_valid = v; b_product = p; b_prod_last = l;
    end
  endtask

  task automatic set_out_ready(input int inst, input logic r);
    if (inst == 0) a_out_ready = r;
    else           b_out_ready = r;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds the beat until prod_ready is seen high before an edge, then drops valid.
  task automatic send_beat(input int inst, input logic signed [15:0] p, input logic l);
    int ov, res, cnt, ovf, pr;
    int guard = 0;
    apply_stimulus(inst, 1'b1, p, l);
    read_out(inst, ov, res, cnt, ovf, pr);
    while (pr == 0 && guard < 20) begin
      tick();
      guard++;
      read_out(inst, ov, res, cnt, ovf, pr);
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout: prod_ready got 0, expected 1");
    end
    tick();
    apply_stimulus(inst, 1'b0, 16'sd0, 1'b0);
  endtask

  task automatic check_result(input string name, input int inst,
                              input int e_res, input int e_cnt, input int e_ovf);
    int ov, res, cnt, ovf, pr;
    read_out(inst, ov, res, cnt, ovf, pr);
    check_output({name, ".out_valid"}, ov, 1);
    check_output({name, ".result"}, res, e_res);
    check_output({name, ".result_cnt"}, cnt, e_cnt);
    check_output({name, ".result_ovf"}, ovf, e_ovf);
  endtask

  task automatic handoff(input string name, input int inst);
    int ov, res, cnt, ovf, pr;
    set_out_ready(inst, 1'b1);
    tick();
    set_out_ready(inst, 1'b0);
    read_out(inst, ov, res, cnt, ovf, pr);
    check_output({name, ".handoff_out_valid"}, ov, 0);
    check_output({name, ".handoff_prod_ready"}, pr, 1);
  endtask

  task automatic check_idle_zero(input string name);
    check_output({name, ".out_valid"}, a_out_valid, 0);
    check_output({name, ".result"}, a_result, 0);
    check_output({name, ".result_cnt"}, a_result_cnt, 0);
    check_output({name, ".result_ovf"}, a_result_ovf, 0);
    check_output({name, ".prod_ready"}, a_prod_ready, 1);
  endtask

  initial begin
    int ov, res, cnt, ovf, pr;
    RST = 1'b1;
    a_clear = 0; a_prod_valid = 0; a_product = 0; a_prod_last = 0; a_out_ready = 0;
    b_clear = 0; b_prod_valid = 0; b_product = 0; b_prod_last = 0; b_out_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_idle_zero("reset");

    vecs[0] = '{"six_beat", 0, 6, 1,
                '{-16'sd4522, 16'sd1846, 16'sd3286, 16'sd7686, -16'sd10, 16'sd3969, 16'sd0, 16'sd0},
                12255, 6, 0};
    vecs[1] = '{"len8_acc20", 0, 8, 0,
                '{16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384,
                  16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384}, 131072, 8, 0};
    vecs[2] = '{"len8_acc18_pos_sat", 1, 8, 0,
                '{16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384,
                  16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384}, 131071, 8, 1};
    vecs[3] = '{"len8_acc18_neg_sat", 1, 8, 0,
                '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
                  -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768}, -131072, 8, 1};
    vecs[4] = '{"sticky_ovf", 1, 6, 1,
                '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767,
                  16'sd32767, -16'sd32768, 16'sd0, 16'sd0}, 98303, 6, 1};
    vecs[5] = '{"three_beat", 0, 3, 1,
                '{16'sd32767, 16'sd32767, -16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                65434, 3, 0};

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        send_beat(vecs[v].inst, vecs[v].p[b], (vecs[v].use_last != 0) && (b == vecs[v].n - 1));
        if (b < vecs[v].n - 1) begin
          read_out(vecs[v].inst, ov, res, cnt, ovf, pr);
          check_output({vecs[v].name, ".early_out_valid"}, ov, 0);
        end
      end
      check_result(vecs[v].name, vecs[v].inst, vecs[v].exp_res, vecs[v].exp_cnt, vecs[v].exp_ovf);
      handoff(vecs[v].name, vecs[v].inst);
    end

    // Backpressure: a waiting beat must not enter while the result is held.
    send_beat(0, 16'sd5, 1'b1);
    apply_stimulus(0, 1'b1, 16'sd100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp.prod_ready", a_prod_ready, 0);
      check_output("bp.result", a_result, 5);
      check_output("bp.out_valid", a_out_valid, 1);
    end
    handoff("bp", 0);
    tick();
    apply_stimulus(0, 1'b0, 16'sd0, 1'b0);
    check_result("bp_next", 0, 100, 1, 0);
    handoff("bp_next", 0);

    // clear mid-vector discards the partial sum.
    for (int i = 0; i < 3; i++) send_beat(0, 16'sd1000, 1'b0);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check_idle_zero("clear");
    repeat (3) tick();
    check_output("clear.no_out_valid", a_out_valid, 0);
    send_beat(0, -16'sd7, 1'b1);
    check_result("after_clear", 0, -7, 1, 0);
    handoff("after_clear", 0);

    // RST while holding a result, then RST together with clear.
    send_beat(0, 16'sd42, 1'b1);
    check_output("rst_done.pre_out_valid", a_out_valid, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_idle_zero("rst_done");
    send_beat(0, 16'sd42, 1'b1);
    check_output("rst_clr.pre_out_valid", a_out_valid, 1);
    RST = 1'b1;
    a_clear = 1'b1;
    tick();
    RST = 1'b0;
    a_clear = 1'b0;
    check_idle_zero("rst_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time got 200000, expected less");
    $fatal(1, "[TB] timeout");
  end

endmodule
